// File: rtl/dfe_pkg.sv
// Shared types and helpers for the DFE output buffering stage.
package dfe_pkg;
  localparam int DFE_DATA_W = 16;

  // Field order matches the flat entry word {ovf, udf, data} stored in the FIFO.
  typedef struct packed {
    logic                  ovf;
    logic                  udf;
    logic [DFE_DATA_W-1:0] data;
  } dfe_out_entry_t;

  // Pointer width including the wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/dfe_fifo_mem.sv
// FIFO storage: synchronous write, combinational read.
module dfe_fifo_mem
  import dfe_pkg::*;
#(
  parameter  int W     = DFE_DATA_W + 2,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  // No reset: stale contents are never visible because reads are gated by empty.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/dfe_out_fifo.sv
// FWFT output FIFO behind the DFE with valid/ready drain and saturating stats.
module dfe_out_fifo
  import dfe_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 16,
  parameter  int AF_LEVEL   = 12,
  parameter  int CNT_WIDTH  = 16,
  localparam int PW         = ptr_w(DEPTH),
  localparam int AW         = PW - 1,
  localparam int EW         = DATA_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  overflow_in,
  input  logic                  underflow_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_ovf,
  output logic                  m_udf,
  output logic [PW-1:0]         level,
  output logic                  almost_full,
  input  logic                  clear_stats,
  output logic [CNT_WIDTH-1:0]  sat_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        level_q, level_d;
  logic                 af_q, af_d;
  logic [CNT_WIDTH-1:0] sat_q, sat_d, drop_q, drop_d;
  logic                 empty, full, push, pop, drop, sat_ev;
  logic [EW-1:0]        rd_entry;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = !empty && m_ready;
  // A pop in the same cycle frees the slot the incoming sample lands in.
  assign push   = valid_in && (!full || pop);
  assign drop   = valid_in && full && !pop;
  assign sat_ev = valid_in && (overflow_in || underflow_in);

  dfe_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({overflow_in, underflow_in, data_in}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + PW'(push) - PW'(pop);
    af_d     = (level_d >= PW'(AF_LEVEL));
    sat_d    = sat_q;
    drop_d   = drop_q;
    if (sat_ev && (sat_q != '1))  sat_d  = sat_q + CNT_WIDTH'(1);
    if (drop && (drop_q != '1))   drop_d = drop_q + CNT_WIDTH'(1);
    if (clear_stats) begin
      sat_d  = '0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      sat_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      af_q     <= af_d;
      sat_q    <= sat_d;
      drop_q   <= drop_d;
    end
  end

  assign m_valid     = !empty;
  assign {m_ovf, m_udf, m_data} = empty ? '0 : rd_entry;
  assign level       = level_q;
  assign almost_full = af_q;
  assign sat_count   = sat_q;
  assign drop_count  = drop_q;
endmodule
